fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 19-bit single-cycle CPU. Holds the program counter, requests one 19-bit instruction at a time from instruction memory over a req/ack handshake, and presents it to the decoder and immediate extender until the core retires it. On retire it computes the next PC: sequential, PC-relative from the extended immediate, or an absolute register/ALU target.

## Interface
Parameters:
- XLEN, 19, datapath and PC width.
- RESET_PC, 19'h00000, PC loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  XLEN  word address of requested instruction (= pc).
- imem_rdata  in  XLEN  instruction word; sampled only when imem_ack=1.
- imem_ack  in  1  memory response valid; ignored unless imem_req=1.
- instr  out  XLEN  fetched instruction to decoder / immediate extender.
- instr_valid  out  1  instr holds a fetched, not-yet-retired instruction.
- retire  in  1  core has executed instr; pcsrc/extimm/alutarget valid this cycle.
- pcsrc  in  2  next-PC select: 00 pc+1, 01 pc+extimm, 10 alutarget, 11 reserved.
- extimm  in  XLEN  sign-extended immediate from the immediate extender.
- alutarget  in  XLEN  absolute jump target from ALU.
- pc  out  XLEN  PC of the current instruction.
- pcplus1  out  XLEN  pc+1 (link value), combinational.
- pc_err  out  1  sticky flag: reserved pcsrc retired.

## Operation
- States: IDLE, FETCH, HOLD. Reset state IDLE.
- IDLE: imem_req=0. Unconditionally -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. Stays until imem_ack=1; on ack, instr<=imem_rdata, -> HOLD. imem_ack in the first FETCH cycle is legal (zero wait states).
- HOLD: instr_valid=1, imem_req=0. Stays until retire=1; on retire, pc<=next_pc, -> FETCH.
- next_pc: 00 -> pc+1; 01 -> pc+extimm; 10 -> alutarget; 11 -> pc+1 and pc_err<=1.
- Arithmetic: all sums modulo 2^XLEN; carry-out discarded (19'h7FFFF+1 = 0). extimm is two's complement; no range check.
- retire outside HOLD is ignored; pcsrc/extimm/alutarget sampled only on retire in HOLD.
- imem_ack outside FETCH is ignored; instr is not modified outside the FETCH ack cycle.
- pc_err is cleared only by reset.
- Reset at any point (including mid-FETCH with ack pending) forces IDLE, drops imem_req asynchronously; a late ack after reset deassertion, while in IDLE, is ignored.

## Timing
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, pc_err=0, pcplus1=RESET_PC+1.
- imem_req, imem_addr, instr_valid decoded from state register (glitch-free, no input-to-output combinational path). pcplus1 combinational from pc.
- First imem_req: first rising edge after reset deasserts moves IDLE->FETCH; req high in cycle 1.
- Fetch latency: instr/instr_valid valid the cycle after the ack edge.
- Minimum throughput: 2 cycles/instruction (ack in first FETCH cycle, retire in first HOLD cycle).
- New pc visible on imem_addr in the cycle after the retire edge.

## Test plan
- Reset release with RESET_PC=0, imem_ack tied 1, retire tied 1, pcsrc=00 -> imem_addr sequence 0,1,2,3 on alternating cycles; instr_valid alternates 0/1; first req in cycle 1.
- imem_ack delayed 3 cycles -> imem_req held high 3 cycles with imem_addr stable; instr captured only on ack cycle; instr_valid rises next cycle.
- pc=0x00010, retire with pcsrc=01, extimm=19'h7FFFC (-4) -> next imem_addr 0x0000C; with pcsrc=10, alutarget=0x12345 -> next imem_addr 0x12345.
- pc=0x7FFFF, retire pcsrc=00 -> next imem_addr 0x00000; pcplus1 reads 0x00000 while pc=0x7FFFF.
- Retire with pcsrc=11 at pc=5 -> next pc 6, pc_err=1 and stays 1 across further retires until reset.
- Assert reset mid-FETCH, then ack one cycle after reset release -> imem_req=0 immediately, pc=RESET_PC, instr=0, late ack ignored, new fetch of RESET_PC begins from IDLE; retire asserted in FETCH has no effect on pc.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per req/ack handshake,
// holds it for the core until retire, then selects the next PC.
module fetch_unit #(
  parameter int              XLEN     = 19,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ack,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            retire,
  input  logic [1:0]      pcsrc,
  input  logic [XLEN-1:0] extimm,
  input  logic [XLEN-1:0] alutarget,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus1,
  output logic            pc_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] next_pc;
  logic            fetch_done;
  logic            retire_now;

  assign fetch_done = (state == FETCH) && imem_ack;
  assign retire_now = (state == HOLD) && retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (imem_ack) state_next = HOLD;
      HOLD:    if (retire)   state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Sums wrap modulo 2^XLEN; the reserved select falls back to sequential.
  always_comb begin
    next_pc = pcplus1;
    case (pcsrc)
      2'b01:   next_pc = pc + extimm;
      2'b10:   next_pc = alutarget;
      default: next_pc = pcplus1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      instr  <= '0;
      pc_err <= 1'b0;
    end else begin
      if (fetch_done) instr <= imem_rdata;
      if (retire_now) begin
        pc <= next_pc;
        if (pcsrc == 2'b11) pc_err <= 1'b1;
      end
    end
  end

  // Handshake outputs come straight from the state register to stay glitch-free.
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == HOLD);
  assign imem_addr   = pc;
  assign pcplus1     = pc + XLEN'(1);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [18:0] imem_addr;
  logic [18:0] imem_rdata;
  logic        imem_ack;
  logic [18:0] instr;
  logic        instr_valid;
  logic        retire;
  logic [1:0]  pcsrc;
  logic [18:0] extimm;
  logic [18:0] alutarget;
  logic [18:0] pc;
  logic [18:0] pcplus1;
  logic        pc_err;

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 = waiting to start a fetch, 1 = awaiting memory, 2 = instruction held.
  int          mphase;
  logic [18:0] mpc;
  logic [18:0] minstr;
  logic        merr;

  fetch_unit #(.XLEN(19), .RESET_PC(19'h00000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr(instr), .instr_valid(instr_valid),
    .retire(retire), .pcsrc(pcsrc), .extimm(extimm), .alutarget(alutarget),
    .pc(pc), .pcplus1(pcplus1), .pc_err(pc_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic checkOutput(input string tag, input logic [18:0] observed, input logic [18:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mphase = 0;
    mpc    = 19'h00000;
    minstr = 19'h00000;
    merr   = 1'b0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic modelStep();
    if (mphase == 0) begin
      mphase = 1;
    end else if (mphase == 1) begin
      if (imem_ack) begin
        minstr = imem_rdata;
        mphase = 2;
      end
    end else if (retire) begin
      case (pcsrc)
        2'b00:   mpc = mpc + 19'd1;
        2'b01:   mpc = mpc + extimm;
        2'b10:   mpc = alutarget;
        default: begin mpc = mpc + 19'd1; merr = 1'b1; end
      endcase
      mphase = 1;
    end
  endtask

  task automatic checkAll();
    logic [18:0] link;
    link = mpc + 19'd1;
    checkOutput("imem_req",    19'(imem_req),    19'(mphase == 1));
    checkOutput("instr_valid", 19'(instr_valid), 19'(mphase == 2));
    checkOutput("imem_addr",   imem_addr,        mpc);
    checkOutput("pc",          pc,               mpc);
    checkOutput("pcplus1",     pcplus1,          link);
    checkOutput("instr",       instr,            minstr);
    checkOutput("pc_err",      19'(pc_err),      19'(merr));
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks the result.
  task automatic applyStimulus(input logic ack, input logic [18:0] rdata, input logic ret,
                               input logic [1:0] src, input logic [18:0] imm, input logic [18:0] tgt);
    imem_ack   = ack;
    imem_rdata = rdata;
    retire     = ret;
    pcsrc      = src;
    extimm     = imm;
    alutarget  = tgt;
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  task automatic runToHold();
    for (int i = 0; i < 10 && mphase != 2; i++)
      applyStimulus(1'b1, 19'($urandom), 1'b0, 2'b00, 19'h0, 19'h0);
    checkOutput("hold_reached", 19'(instr_valid), 19'd1);
  endtask

  task automatic retireWith(input logic [1:0] src, input logic [18:0] imm, input logic [18:0] tgt);
    runToHold();
    applyStimulus(1'b0, 19'h0, 1'b1, src, imm, tgt);
  endtask

  initial begin
    reset = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0; retire = 1'b0;
    pcsrc = 2'b00; extimm = '0; alutarget = '0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    reset = 1'b0;
    checkAll();

    $display("[TB] streaming fetch with ack and retire tied high");
    applyStimulus(1'b1, 19'h10001, 1'b1, 2'b00, 19'h0, 19'h0);
    checkOutput("first_req", 19'(imem_req), 19'd1);
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b1, 19'h10002 + 19'(i), 1'b1, 2'b00, 19'h0, 19'h0);
    checkOutput("stream_pc", pc, 19'd3);

    $display("[TB] delayed acknowledge");
    applyStimulus(1'b0, 19'h0, 1'b1, 2'b00, 19'h0, 19'h0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 19'($urandom), 1'b0, 2'b00, 19'h0, 19'h0);
    applyStimulus(1'b1, 19'h2ABCD, 1'b0, 2'b00, 19'h0, 19'h0);
    checkOutput("delayed_instr", instr, 19'h2ABCD);

    $display("[TB] relative and absolute jumps");
    retireWith(2'b10, 19'h0, 19'h00010);
    retireWith(2'b01, 19'h7FFFC, 19'h0);
    checkOutput("rel_addr", imem_addr, 19'h0000C);
    retireWith(2'b10, 19'h0, 19'h12345);
    checkOutput("abs_addr", imem_addr, 19'h12345);

    $display("[TB] PC wraparound");
    retireWith(2'b10, 19'h0, 19'h7FFFF);
    checkOutput("wrap_pcplus1", pcplus1, 19'h00000);
    retireWith(2'b00, 19'h0, 19'h0);
    checkOutput("wrap_addr", imem_addr, 19'h00000);

    $display("[TB] reserved pcsrc");
    retireWith(2'b10, 19'h0, 19'h00005);
    retireWith(2'b11, 19'h0, 19'h0);
    checkOutput("rsvd_pc", pc, 19'h00006);
    checkOutput("rsvd_err", 19'(pc_err), 19'd1);
    retireWith(2'b00, 19'h0, 19'h0);
    retireWith(2'b01, 19'h00003, 19'h0);
    checkOutput("err_sticky", 19'(pc_err), 19'd1);

    $display("[TB] retire in fetch and reset mid-fetch");
    applyStimulus(1'b0, 19'h0, 1'b1, 2'b10, 19'h0, 19'h55555);
    checkOutput("fetch_retire_pc", pc, 19'h0000A);
    imem_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_req", 19'(imem_req), 19'd0);
    checkOutput("rst_pc", pc, 19'h00000);
    checkOutput("rst_err", 19'(pc_err), 19'd0);
    @(negedge clk);
    reset = 1'b0;
    checkAll();
    applyStimulus(1'b1, 19'h07777, 1'b0, 2'b00, 19'h0, 19'h0);
    checkOutput("late_ack_instr", instr, 19'h00000);
    checkOutput("refetch_req", 19'(imem_req), 19'd1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        #3 reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        reset = 1'b0;
      end
      applyStimulus(1'($urandom_range(0, 1)), 19'($urandom), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 19'($urandom), 19'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
